// File: rtl/kyber_absorb_feeder.sv
// Writer side of the Keccak input FIFO: streams message RAM words (plus an
// optional XOF index tail word) into the core FIFO, then waits for the permutation.
module kyber_absorb_feeder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [5:0]        cmd_words,
    input  logic [1:0]        cmd_mode,
    input  logic              cmd_append,
    input  logic [7:0]        cmd_i,
    input  logic [7:0]        cmd_j,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              ififo_full,
    input  logic              ififo_empty,
    input  logic              keccak_ready,
    output logic              ififo_wen,
    output logic [31:0]       ififo_din,
    output logic              ififo_absorb,
    output logic [1:0]        ififo_mode,
    output logic              ififo_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE, READ, LATCH, WRITE, TAIL, WAIT, DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [5:0]        words_q;
    logic [1:0]        mode_q;
    logic              append_q;
    logic [7:0]        i_q;
    logic [7:0]        j_q;
    logic [5:0]        idx;
    logic [31:0]       data_q;
    logic              seen_low;

    logic       accept;
    logic [6:0] idx_next;
    logic       wr_word;
    logic       wr_tail;

    assign accept   = cmd_valid && (state == IDLE);
    assign idx_next = {1'b0, idx} + 7'd1;
    assign wr_word  = (state == WRITE);
    assign wr_tail  = (state == TAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            words_q  <= '0;
            mode_q   <= '0;
            append_q <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            idx      <= '0;
            data_q   <= '0;
            seen_low <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        base_q   <= cmd_base;
                        words_q  <= cmd_words;
                        mode_q   <= cmd_mode;
                        append_q <= cmd_append;
                        i_q      <= cmd_i;
                        j_q      <= cmd_j;
                        idx      <= '0;
                        seen_low <= 1'b0;
                        if (cmd_words == 6'd0 && !cmd_append)
                            state <= DONE;
                        else if (cmd_words != 6'd0)
                            state <= READ;
                        else
                            state <= TAIL;
                    end
                end
                READ: state <= LATCH;
                LATCH: begin
                    data_q <= mem_rdata;
                    state  <= WRITE;
                end
                WRITE: begin
                    // data_q is held untouched while the FIFO back-pressures
                    if (!ififo_full) begin
                        idx <= idx + 6'd1;
                        if (idx_next < {1'b0, words_q})
                            state <= READ;
                        else if (append_q)
                            state <= TAIL;
                        else
                            state <= WAIT;
                    end
                end
                TAIL: begin
                    if (!ififo_full)
                        state <= WAIT;
                end
                WAIT: begin
                    // a stale DONE level from the previous job must not end this one
                    if (!keccak_ready)
                        seen_low <= 1'b1;
                    if (seen_low && keccak_ready && ififo_empty)
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign mem_ren      = (state == READ);
    assign mem_addr     = mem_ren ? base_q + ADDR_W'(idx) : '0;
    assign ififo_wen    = (wr_word || wr_tail) && !ififo_full;
    assign ififo_absorb = ififo_wen;
    assign ififo_mode   = mode_q;

    always_comb begin
        ififo_din = '0;
        if (wr_word)
            ififo_din = data_q;
        else if (wr_tail)
            ififo_din = {16'h0, i_q, j_q};
    end

    assign ififo_last = ififo_wen &&
        (wr_tail || (!append_q && idx_next == {1'b0, words_q}));

endmodule

// File: tb/tb_kyber_absorb_feeder.sv
// Self-checking bench for kyber_absorb_feeder: queue-based write model plus
// directed timing checks for done, back-pressure, command gating and reset.
module tb_kyber_absorb_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_base;
    logic [5:0]  cmd_words;
    logic [1:0]  cmd_mode;
    logic        cmd_append;
    logic [7:0]  cmd_i;
    logic [7:0]  cmd_j;
    logic        mem_ren;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        ififo_full;
    logic        ififo_empty;
    logic        keccak_ready;
    logic        ififo_wen;
    logic [31:0] ififo_din;
    logic        ififo_absorb;
    logic [1:0]  ififo_mode;
    logic        ififo_last;
    logic        busy;
    logic        done;

    kyber_absorb_feeder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_words(cmd_words),
        .cmd_mode(cmd_mode), .cmd_append(cmd_append),
        .cmd_i(cmd_i), .cmd_j(cmd_j),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .ififo_full(ififo_full), .ififo_empty(ififo_empty),
        .keccak_ready(keccak_ready),
        .ififo_wen(ififo_wen), .ififo_din(ififo_din),
        .ififo_absorb(ififo_absorb), .ififo_mode(ififo_mode),
        .ififo_last(ififo_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [256];
    always @(posedge clk)
        if (mem_ren) mem_rdata <= ram[mem_addr];

    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_count = 0;
    int          ren_count = 0;
    logic [31:0] exp_din [$];
    logic        exp_last [$];
    logic [1:0]  exp_mode = 2'd0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Every write is checked against the expected-message queue
    always @(negedge clk) begin
        if (!rst) begin
            chk("wen_while_full", 32'(ififo_wen & ififo_full), 0);
            chk("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
            chk("done_and_ready", 32'(done & cmd_ready), 0);
            if (mem_ren) ren_count++;
            if (ififo_wen) begin
                wr_count++;
                if (exp_din.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_write: got %h expected none", ififo_din);
                end else begin
                    chk("din", ififo_din, exp_din.pop_front());
                    chk("last", 32'(ififo_last), 32'(exp_last.pop_front()));
                    chk("absorb", 32'(ififo_absorb), 1);
                    chk("mode", 32'(ififo_mode), 32'(exp_mode));
                end
            end
        end
    end

    task automatic issue(input logic [7:0] b, input logic [5:0] w,
                         input logic [1:0] m, input logic a,
                         input logic [7:0] i, input logic [7:0] j);
        cmd_base = b; cmd_words = w; cmd_mode = m;
        cmd_append = a; cmd_i = i; cmd_j = j;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_base = 8'hEE; cmd_words = 6'd17; cmd_mode = 2'd2;
        cmd_append = 1'b1; cmd_i = 8'hAA; cmd_j = 8'hBB;
    endtask

    task automatic push_ram(input logic [7:0] b, input int w, input logic a,
                            input logic [7:0] i, input logic [7:0] j);
        for (int k = 0; k < w; k++) begin
            exp_din.push_back(ram[8'(int'(b) + k)]);
            exp_last.push_back(!a && k == w - 1);
        end
        if (a) begin
            exp_din.push_back({16'h0, i, j});
            exp_last.push_back(1'b1);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && exp_din.size() != 0; c++) begin
            @(negedge clk); #1;
        end
        chk("drain", exp_din.size(), 0);
    endtask

    task automatic wait_writes(input int target, input int budget);
        for (int c = 0; c < budget && wr_count < target; c++) begin
            @(negedge clk); #1;
        end
        chk("wait_writes", 32'(wr_count >= target), 1);
    endtask

    // Called right after the final write cycle; ready was low on entry
    task automatic wait_done(input int empty_hold);
        @(posedge clk);
        @(posedge clk); #1;
        keccak_ready = 1'b1;
        ififo_empty = (empty_hold == 0);
        @(negedge clk);
        chk("done_early", 32'(done), 0);
        for (int c = 1; c < empty_hold; c++) begin
            @(negedge clk);
            chk("done_not_empty", 32'(done), 0);
        end
        if (empty_hold != 0) begin
            @(posedge clk); #1;
            ififo_empty = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", 32'(done), 1);
        @(posedge clk); #1;
        keccak_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_after_done", 32'(cmd_ready), 1);
    endtask

    task automatic push_lit_9();
        for (int k = 0; k < 8; k++) begin
            exp_din.push_back(32'(k));
            exp_last.push_back(1'b0);
        end
        exp_din.push_back(32'h0000_0102);
        exp_last.push_back(1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int w0;
        int r0;
        for (int a = 0; a < 256; a++)
            ram[a] = (a < 8) ? 32'(a) : (32'hC0DE_0000 | 32'(a));
        rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_words = '0;
        cmd_mode = '0; cmd_append = 1'b0; cmd_i = '0; cmd_j = '0;
        ififo_full = 1'b0; ififo_empty = 1'b1; keccak_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_outs", {ififo_din[23:0], mem_addr}, 0);
        chk("rst_flags", {ififo_wen, mem_ren, busy, done,
                          ififo_last, ififo_absorb, ififo_mode}, 0);

        // 8 words + tail, with a command pulse ignored mid-transfer
        w0 = wr_count;
        exp_mode = 2'd3;
        push_lit_9();
        issue(8'h00, 6'd8, 2'd3, 1'b1, 8'h01, 8'h02);
        wait_writes(w0 + 2, 50);
        cmd_valid = 1'b1; cmd_base = 8'h80; cmd_words = 6'd1; cmd_append = 1'b0;
        chk("busy_ready", 32'(cmd_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("busy_ready2", 32'(cmd_ready), 0);
        #1 cmd_valid = 1'b0;
        wait_drain(200);
        chk("writes_t1", wr_count - w0, 9);
        wait_done(3);

        // Same command, FIFO full for 5 cycles during word 3's write
        w0 = wr_count;
        push_lit_9();
        issue(8'h00, 6'd8, 2'd3, 1'b1, 8'h01, 8'h02);
        for (int c = 0; c < 50 && !(mem_ren && mem_addr == 8'd3); c++)
            @(negedge clk);
        chk("saw_read3", 32'(mem_ren && mem_addr == 8'd3), 1);
        @(posedge clk);
        @(posedge clk); #1;
        ififo_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_wen", 32'(ififo_wen), 0);
            chk("hold_din", ififo_din, 32'd3);
        end
        @(posedge clk); #1;
        ififo_full = 1'b0;
        wait_drain(200);
        chk("writes_t2", wr_count - w0, 9);
        wait_done(0);

        // Empty command: immediate done, no traffic
        w0 = wr_count;
        r0 = ren_count;
        issue(8'h10, 6'd0, 2'd1, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("zero_done", 32'(done), 1);
        chk("zero_ready_low", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("zero_ready", 32'(cmd_ready), 1);
        chk("zero_done_off", 32'(done), 0);
        chk("zero_writes", wr_count - w0, 0);
        chk("zero_reads", ren_count - r0, 0);

        // Keccak already done at start: must see it go low first
        w0 = wr_count;
        exp_mode = 2'd1;
        keccak_ready = 1'b1;
        push_ram(8'h40, 4, 1'b0, 8'h00, 8'h00);
        issue(8'h40, 6'd4, 2'd1, 1'b0, 8'h00, 8'h00);
        wait_drain(100);
        chk("writes_t4", wr_count - w0, 4);
        repeat (5) begin
            @(negedge clk);
            chk("no_done_stale", 32'(done), 0);
        end
        #1 keccak_ready = 1'b0;
        repeat (30) begin
            @(negedge clk);
            chk("no_done_low", 32'(done), 0);
        end
        @(posedge clk); #1;
        keccak_ready = 1'b1;
        @(negedge clk);
        chk("done_not_at_rise", 32'(done), 0);
        @(posedge clk);
        @(negedge clk);
        chk("done_after_rise", 32'(done), 1);
        @(posedge clk); #1;
        keccak_ready = 1'b0;

        // Reset mid-transfer, then restart at a wrapping base address
        w0 = wr_count;
        exp_mode = 2'd2;
        push_ram(8'h20, 8, 1'b0, 8'h00, 8'h00);
        issue(8'h20, 6'd8, 2'd2, 1'b0, 8'h00, 8'h00);
        wait_writes(w0 + 4, 50);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_din.delete();
        exp_last.delete();
        @(negedge clk);
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        chk("mid_rst_flags", {ififo_wen, mem_ren, busy, done,
                              ififo_last, ififo_absorb, ififo_mode}, 0);
        chk("mid_rst_data", ififo_din | 32'(mem_addr), 0);
        w0 = wr_count;
        exp_mode = 2'd0;
        push_ram(8'hFE, 4, 1'b1, 8'h33, 8'h44);
        issue(8'hFE, 6'd4, 2'd0, 1'b1, 8'h33, 8'h44);
        for (int c = 0; c < 10 && !mem_ren; c++)
            @(negedge clk);
        chk("restart_ren", 32'(mem_ren), 1);
        chk("restart_addr", 32'(mem_addr), 32'hFE);
        wait_drain(100);
        chk("writes_t6", wr_count - w0, 5);
        wait_done(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
